mips_seq_divider: RTL and testbench
===================================

// Module: mips_seq_divider
// PURPOSE
//   Multi-cycle restoring divider for MIPS DIV/DIVU. Downstream consumer of the
//   team's 32-bit ripple subtractor: issues one trial subtraction per cycle and
//   keeps or discards the difference. Results are written to the HI/LO
//   registers. The single-cycle datapath stalls on busy.
// PARAMETERS
//   WIDTH  32  operand width; verified only at 32
// PORTS
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous active-low reset
//   start         in   1      request; sampled only in IDLE
//   is_signed     in   1      1 = DIV (two's complement), 0 = DIVU
//   dividend      in   WIDTH  rs operand; sampled with start
//   divisor       in   WIDTH  rt operand; sampled with start
//   busy          out  1      high from the cycle after start until done
//   done          out  1      one-cycle pulse; lo/hi valid from this cycle
//   lo            out  WIDTH  quotient; held until the next accepted start
//   hi            out  WIDTH  remainder; held until the next accepted start
//   div_by_zero   out  1      set with done when divisor == 0; held like lo/hi
// BEHAVIOUR
//   Reset (async, rst_n = 0):
//     - state = IDLE; busy, done, div_by_zero, lo, hi, count all clear to 0.
//     - Reset mid-operation aborts the operation. No partial result appears.
//   States: IDLE -> CALC -> DONE -> IDLE.
//   IDLE, start = 1 at clock edge k:
//     - Latch the magnitudes of dividend and divisor. If is_signed, negate
//       negative operands. Record the quotient sign (sign_a ^ sign_b) and the
//       remainder sign (sign_a).
//     - Clear R and set count = 0.
//     - If divisor == 0, go to DONE instead of CALC.
//   CALC, one quotient bit per cycle, MSB first, 32 cycles (count 0..31):
//     - t = {R[30:0], Q[31]}; Q shifts left.
//     - diff = t - D, computed by the 32-bit subtractor with carry_in = 1.
//       carry_out = 1 means no borrow.
//     - accept = R[31] | carry_out. The R[31] term covers the implicit 33rd bit.
//     - accept = 1: R = diff, Q[0] = 1. accept = 0: R = t, Q[0] = 0.
//     - After count == 31, go to DONE.
//   DONE, one cycle:
//     - done = 1, busy = 0.
//     - lo = Q, negated if the quotient sign is 1.
//     - hi = R, negated if the remainder sign is 1.
//     - Then go to IDLE.
//   Timing:
//     - Normal operation: busy = 1 on cycles k+1..k+32; done at cycle k+33.
//     - Divide by zero: done at cycle k+1, busy never rises.
//       lo = 0xFFFFFFFF, hi = dividend unmodified, div_by_zero = 1.
//   Boundary cases:
//     - Signed 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
//       This wraps and is not flagged.
//     - Rounding is truncation toward zero. The remainder takes the sign of
//       the dividend; a zero remainder is never negated to a nonzero value.
//   Handshake:
//     - start while busy or in DONE is ignored. No queueing.
//     - start in the IDLE cycle right after a done is accepted normally.
//     - Operand changes after the start edge have no effect.
//   Outputs: lo/hi/div_by_zero change only in DONE (or on reset).
// TESTING
//   1. DIVU 100 / 7, start at cycle 0 -> busy on cycles 1..32, done at 33,
//      lo = 14, hi = 2, div_by_zero = 0.
//   2. DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
//      DIV 7 / -2 -> lo = 0xFFFFFFFD, hi = 1.
//   3. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
//      DIVU 0xFFFFFFFF / 1 -> lo = 0xFFFFFFFF, hi = 0.
//   4. DIVU 1234 / 0 -> done at cycle 1, lo = 0xFFFFFFFF, hi = 1234,
//      div_by_zero = 1.
//   5. Start 50 / 5, then re-pulse start at cycle 10 with 9 / 3 -> ignored.
//      Done at 33 with lo = 10, hi = 0.
//   6. rst_n low at cycle 15 of an operation -> all outputs 0 immediately, no
//      done. A new DIVU 9 / 4 then gives lo = 2, hi = 1 after 33 cycles.

Source files
------------

// File: rtl/mips_seq_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one quotient bit per cycle, MSB first.
// Results land in HI/LO; divide by zero completes in one cycle with a flag.
module mips_seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             dbz_q, dbz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] trial, diff;
    logic             carry_out, accept;

    assign a_neg = is_signed & dividend[WIDTH-1];
    assign b_neg = is_signed & divisor[WIDTH-1];
    assign a_mag = a_neg ? (WIDTH'(0) - dividend) : dividend;
    assign b_mag = b_neg ? (WIDTH'(0) - divisor) : divisor;

    // Trial subtraction as t + ~D + 1; carry_out = 1 means no borrow.
    assign trial = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign {carry_out, diff} = {1'b0, trial} + {1'b0, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};
    // rem_q[MSB] stands in for the shifted-out 33rd bit of t.
    assign accept = rem_q[WIDTH-1] | carry_out;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    rem_d   = '0;
                    count_d = '0;
                    if (divisor == '0) begin
                        lo_d    = '1;
                        hi_d    = dividend;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d   = accept ? diff : trial;
                quo_d   = {quo_q[WIDTH-2:0], accept};
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    lo_d    = q_neg_q ? (WIDTH'(0) - quo_d) : quo_d;
                    hi_d    = r_neg_q ? (WIDTH'(0) - rem_d) : rem_d;
                    dbz_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == StCalc);
    assign done        = (state_q == StDone);
    assign lo          = lo_q;
    assign hi          = hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_seq_divider.sv
// Directed bench for mips_seq_divider: expected results queued at issue time,
// a negedge monitor pops and compares whenever done is seen.
module tb_mips_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] lo, hi;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        string       name;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t sb[$];

    mips_seq_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .lo         (lo),
        .hi         (hi),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, ".lo"}, lo, e.lo);
                chk({e.name, ".hi"}, hi, e.hi);
                chk({e.name, ".dbz"}, {31'b0, div_by_zero}, {31'b0, e.dbz});
                chk({e.name, ".cycle"}, cyc, e.due);
            end
        end
    end

    // Drive one start; s is the cycle in which start is held high.
    task automatic issue(input string nm, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input bit push, input logic [31:0] elo,
                         input logic [31:0] ehi, input logic edbz, output int s);
        exp_t e;
        @(negedge clk);
        s = cyc;
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom);
        if (push) begin
            e.name = nm;
            e.lo   = elo;
            e.hi   = ehi;
            e.dbz  = edbz;
            e.due  = s + (edbz ? 1 : 33);
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s.timeout: got pending=%0d expected 0 within 60 cycles", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int s;
        repeat (2) @(negedge clk);
        chk("reset.busy", {31'b0, busy}, 32'd0);
        chk("reset.done", {31'b0, done}, 32'd0);
        chk("reset.lo", lo, 32'd0);
        chk("reset.hi", hi, 32'd0);
        chk("reset.dbz", {31'b0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        // DIVU 100/7 with busy profile across the whole operation
        issue("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, s);
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            chk($sformatf("busy@%0d", i), {31'b0, busy}, {31'b0, (i <= 32)});
        end
        wait_idle("divu_100_7");

        issue("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, s);
        wait_idle("div_m7_2");
        issue("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, s);
        wait_idle("div_7_m2");
        issue("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,
              1'b0, s);
        wait_idle("div_min_m1");
        issue("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, s);
        wait_idle("divu_max_1");
        issue("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000,
              1'b0, s);
        wait_idle("divu_big");
        issue("div_m8_m3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 32'd2, 32'hFFFF_FFFE,
              1'b0, s);
        wait_idle("div_m8_m3");
        issue("div_m6_3", 1'b1, 32'hFFFF_FFFA, 32'd3, 1'b1, 32'hFFFF_FFFE, 32'd0, 1'b0, s);
        wait_idle("div_m6_3");
        issue("divu_5_10", 1'b0, 32'd5, 32'd10, 1'b1, 32'd0, 32'd5, 1'b0, s);
        wait_idle("divu_5_10");

        // Divide by zero: one-cycle completion, busy stays low
        issue("divu_by0", 1'b0, 32'd1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd1234, 1'b1, s);
        @(negedge clk);
        chk("divu_by0.busy", {31'b0, busy}, 32'd0);
        wait_idle("divu_by0");
        issue("div_by0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, s);
        wait_idle("div_by0");

        // Start while busy is ignored
        issue("divu_50_5", 1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0, s);
        repeat (8) @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_idle("divu_50_5");

        // Reset mid-operation: outputs clear at once, no done follows
        issue("abort", 1'b0, 32'd100, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, s);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", {31'b0, busy}, 32'd0);
        chk("abort.done", {31'b0, done}, 32'd0);
        chk("abort.lo", lo, 32'd0);
        chk("abort.hi", hi, 32'd0);
        chk("abort.dbz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue("divu_9_4", 1'b0, 32'd9, 32'd4, 1'b1, 32'd2, 32'd1, 1'b0, s);
        wait_idle("divu_9_4");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
